// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters; IF-stage lookup, EX-stage training.
// Optional macro BP_STATS_EN adds free-running branch and mispredict counters.
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] PC_IF,
  output logic            predict_taken_IF,
  output logic [PC_W-1:0] predict_target_IF,
  input  logic            br_valid_EX,
  input  logic [PC_W-1:0] PC_EX,
  input  logic            br_taken_EX,
  input  logic [PC_W-1:0] br_target_EX,
  input  logic            predict_taken_EX,
  output logic            mispredict_EX
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int TAG_W   = PC_W - IDX_W - 2;
  localparam int ENTRIES = 1 << IDX_W;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic             valid_q [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [1:0]       ex_ctr_next;
  logic             unused_pc_bits;

  assign if_idx = PC_IF[IDX_W+1:2];
  assign if_tag = PC_IF[PC_W-1:IDX_W+2];
  assign ex_idx = PC_EX[IDX_W+1:2];
  assign ex_tag = PC_EX[PC_W-1:IDX_W+2];
  assign unused_pc_bits = ^{PC_IF[1:0], PC_EX[1:0]};

  // Target is forced to zero unless taken, so uninitialised target storage never leaks out.
  always_comb begin
    if_hit            = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    predict_taken_IF  = if_hit && ctr_q[if_idx][1];
    predict_target_IF = predict_taken_IF ? tgt_q[if_idx] : '0;
  end

  assign mispredict_EX = br_valid_EX && (predict_taken_EX != br_taken_EX);

  always_comb begin
    ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_ctr_next = ctr_q[ex_idx];
    if (br_taken_EX) begin
      if (ctr_q[ex_idx] != CTR_ST) ex_ctr_next = ctr_q[ex_idx] + 2'b01;
    end else begin
      if (ctr_q[ex_idx] != CTR_SNT) ex_ctr_next = ctr_q[ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (br_valid_EX) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ex_ctr_next;
      end else if (br_taken_EX) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= CTR_WT;
      end
    end
  end

  // Tag and target need no reset: any taken resolution writes both, which covers
  // the hit case (tag unchanged) and allocation alike; valid gates their use.
  always_ff @(posedge clk) begin
    if (br_valid_EX && br_taken_EX) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= br_target_EX;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (br_valid_EX)   stat_branches    <= stat_branches + 32'd1;
      if (mispredict_EX) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
